// File: rtl/vedic_mul_arbiter.sv
// Round-robin front end that shares one pipelined multiplier between NREQ requesters.
// A tag pipeline matched to the multiplier latency routes each product back to its issuer.
module vedic_mul_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 4,
  parameter int LATENCY = 5,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(LATENCY + 3)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic                    mul_vld,
  input  logic [2*WIDTH-1:0]      mul_result,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic [CW-1:0]           inflight
);

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             tag_vld [0:LATENCY];
  logic [IW-1:0]    tag_idx [0:LATENCY];
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             rsp_now;

  // First active requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(j);
        gnt[j]  = 1'b1;
      end
    end
  end

  assign sel_a   = a_in[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_b   = b_in[int'(gnt_idx)*WIDTH +: WIDTH];
  assign rsp_now = |rsp_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_vld <= 1'b0;
    end else begin
      mul_vld <= gnt_any;
      if (gnt_any) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
        ptr   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
    end
  end

  // Stage LATENCY lines up with mul_result for the op it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_vld[s] <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      tag_vld[0] <= gnt_any;
      tag_idx[0] <= gnt_idx;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_vld[LATENCY] ? (NREQ'(1) << tag_idx[LATENCY]) : '0;
      if (tag_vld[LATENCY]) rsp_data <= mul_result;
    end
  end

  // An op leaves the count on the edge after its response strobe is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({gnt_any, rsp_now})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
